// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, default load clamp and BCD digit width for the countdown timer
package timer_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUNNING = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;
  localparam int DEFAULT_MAX_SECONDS = 99;
  localparam int BCD_W = 4;
endpackage

// File: rtl/bin_to_bcd2.sv
// bin_to_bcd2: combinational split of a 0..99 binary value into BCD tens and ones digits
module bin_to_bcd2
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);
  assign tens = BCD_W'(value / WIDTH'(10));
  assign ones = BCD_W'(value % WIDTH'(10));
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable seconds countdown driven by a 1 Hz enable, with BCD outputs; TIMER_WARN_EN adds a warning blink
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_SECONDS = DEFAULT_MAX_SECONDS
`ifdef TIMER_WARN_EN
  , parameter int WARN_THRESH = 5
`endif
) (
  input  logic             clock_65mhz,
  input  logic             reset_n,
  input  logic             one_hz_enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             go,
  input  logic             pause,
  output logic             restart_one_hz,
  output logic [WIDTH-1:0] seconds_left,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             running,
  output logic             expired,
  output logic [1:0]       timer_state,
  output logic             warn
);
  logic [1:0]       next_state;
  logic [WIDTH-1:0] next_secs, clamped, dec;
  logic [BCD_W-1:0] next_tens, next_ones;
  logic             hit_zero;
  assign clamped  = (load_value > WIDTH'(MAX_SECONDS)) ? WIDTH'(MAX_SECONDS) : load_value;
  assign dec      = seconds_left - WIDTH'(1);
  assign hit_zero = timer_state == RUNNING && one_hz_enable && dec == '0;
  // next state and count: load > go > pause > tick, with a tick to zero overriding pause
  always_comb begin
    next_state = timer_state;
    next_secs  = seconds_left;
    case (timer_state)
      IDLE:
        if (load) next_secs = clamped;
        else if (go && seconds_left != '0) next_state = RUNNING;
      RUNNING: begin
        if (one_hz_enable) next_secs = dec;
        if (hit_zero) next_state = EXPIRED;
        else if (pause) next_state = PAUSED;
      end
      PAUSED:
        if (load) begin
          next_secs  = clamped;
          next_state = IDLE;
        end else if (go) next_state = RUNNING;
      default:
        if (load) begin
          next_secs  = clamped;
          next_state = IDLE;
        end
    endcase
  end
  bin_to_bcd2 #(.WIDTH(WIDTH)) u_bcd (
    .value(next_secs),
    .tens (next_tens),
    .ones (next_ones)
  );
  // output registers; BCD digits come from the next count so they never lag seconds_left
  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      timer_state    <= IDLE;
      seconds_left   <= '0;
      tens           <= '0;
      ones           <= '0;
      running        <= 1'b0;
      expired        <= 1'b0;
      restart_one_hz <= 1'b1;
    end else begin
      timer_state    <= next_state;
      seconds_left   <= next_secs;
      tens           <= next_tens;
      ones           <= next_ones;
      running        <= next_state == RUNNING;
      expired        <= hit_zero;
      restart_one_hz <= next_state != RUNNING;
    end
  end
`ifdef TIMER_WARN_EN
  logic in_win, was_win, next_warn;
  assign in_win    = next_state == RUNNING && next_secs != '0 && next_secs <= WIDTH'(WARN_THRESH);
  assign was_win   = running && seconds_left != '0 && seconds_left <= WIDTH'(WARN_THRESH);
  assign next_warn = in_win && (!was_win || (one_hz_enable ? !warn : warn));
  // blink starts high on entering the window and toggles per tick while inside it
  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) warn <= 1'b0;
    else warn <= next_warn;
  end
`else
  assign warn = 1'b0;
`endif
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Seconds countdown timer that sits directly downstream of the 1 Hz enable generator and consumes its once-per-second enable pulse.
- Also drives that generator's restart input, so every run or resume begins with a full second.
- Holds a loadable seconds count, runs/pauses/expires under control pulses from game logic, and presents the count as two BCD digits for the display path.

Parameters:
WIDTH, 8, width of seconds counter
MAX_SECONDS, 99, load clamp; keeps count representable as two BCD digits
WARN_THRESH, 5, remaining-seconds threshold for warning blink (optional feature only)

Ports:
clock_65mhz  input  1  system clock, 65 MHz
reset_n  input  1  asynchronous, active-low reset
one_hz_enable  input  1  one-cycle tick from 1 Hz generator
load  input  1  pulse: capture load_value
load_value  input  WIDTH  seconds to load
go  input  1  pulse: start or resume
pause  input  1  pulse: suspend countdown
restart_one_hz  output  1  drives the 1 Hz generator's start input
seconds_left  output  WIDTH  remaining seconds
tens  output  4  BCD tens digit of seconds_left
ones  output  4  BCD ones digit of seconds_left
running  output  1  high while in RUNNING
expired  output  1  one-cycle pulse on reaching zero
timer_state  output  2  current FSM state
warn  output  1  blink output (optional feature)

Behaviour:
- Clock and reset are fixed: one clock, clock_65mhz; reset_n is asynchronous and active-low.
- Reset values while reset_n is low:
  - State IDLE.
  - seconds_left = 0, tens = 0, ones = 0.
  - running = 0, expired = 0, warn = 0.
  - restart_one_hz = 1.
- Reset mid-run abandons the count with no expired pulse.
- All outputs are registered.
- restart_one_hz is the registered value of (next_state != RUNNING). The generator is therefore held cleared whenever the timer is not running.
- States, with transitions evaluated each rising edge. Priority is load > go > pause > tick.
  - IDLE:
    - load: seconds_left <= min(load_value, MAX_SECONDS); stay IDLE.
    - go with seconds_left != 0: enter RUNNING.
    - go with seconds_left == 0: ignored.
  - RUNNING:
    - one_hz_enable: seconds_left decrements by 1.
    - If the decrement produces 0: enter EXPIRED and assert expired for exactly one cycle, on the same edge.
    - pause: enter PAUSED.
    - load and go: ignored.
  - PAUSED:
    - Count frozen; one_hz_enable ignored.
    - go: enter RUNNING.
    - load: reload as in IDLE, then enter IDLE.
  - EXPIRED:
    - seconds_left stays 0; go and pause ignored.
    - load: reload, then enter IDLE.
- Simultaneous pause and one_hz_enable in RUNNING:
  - The tick is applied first, so the decrement counts, then the state goes to PAUSED.
  - If that tick reaches 0, the state goes to EXPIRED instead, with the expired pulse.
- Resume after pause: restart_one_hz drops on the edge entering RUNNING. The partial second before the pause is discarded, and the next tick arrives one full generator period later.
- Arithmetic:
  - The decrement never wraps; a tick at 0 is impossible because the count only runs from RUNNING.
  - The clamp is an unsigned compare.
- tens/ones: registered BCD split of the next seconds_left value, updated on the same edge as seconds_left, so there is 0 cycles of skew.
- running = (state == RUNNING).
- timer_state encoding: IDLE = 0, RUNNING = 1, PAUSED = 2, EXPIRED = 3.

Optional Feature:
TIMER_WARN_EN
- Defined:
  - While RUNNING with 0 < seconds_left <= WARN_THRESH, warn toggles on each one_hz_enable.
  - On entering the window, warn starts at 1.
  - warn is forced to 0 in every other state and whenever seconds_left is outside the window.
- Undefined: warn is tied to 0 and no toggle logic is synthesised.

Decomposition:
- Shared package (timer_pkg):
  - State encoding localparams IDLE/RUNNING/PAUSED/EXPIRED.
  - Default MAX_SECONDS.
  - BCD digit width (4).
- One natural sub-module, bin_to_bcd2: combinational WIDTH-bit value (0..99) to tens/ones digits. The countdown_timer output registers capture its result.

Test Plan:
- Reset mid-RUNNING with seconds_left 7 -> immediately IDLE, seconds_left 0, restart_one_hz 1, no expired pulse.
- Load 10, go, 10 bench ticks spaced 5 cycles -> seconds_left steps 9..0, tens/ones 0/9..0/0, expired high exactly one cycle on the 10th tick edge, state EXPIRED, restart_one_hz 1.
- Load 150 -> seconds_left 99, tens 9, ones 9; load 0 then go -> stays IDLE, running 0.
- Load 20, go, 3 ticks, pause -> holds 17 through 5 further ticks, restart_one_hz 1 while PAUSED; go -> RUNNING, next tick gives 16.
- At seconds_left 1, pause and one_hz_enable in same cycle -> EXPIRED, seconds_left 0, expired pulse; load and go while RUNNING are ignored with count unchanged.
- With TIMER_WARN_EN defined, load 7, go, ticks -> warn 0 at 7 and 6, 1 at 5, 0 at 4, 1 at 3, 0 at 2, 1 at 1, 0 in EXPIRED; without the macro, warn is constantly 0.
